fp_div: RTL and testbench

- Iterative IEEE-754 single-precision divider: result = a / b.
- Inverse-operation companion to the team's pipelined FP multiplier; uses the same simplified number model (truncation, flush-to-zero, flag outputs).
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Sits behind a start/ready/done handshake for the arithmetic datapath controller.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_div_mant_step.sv | 21 ++
 rtl/fp_div.sv | 178 +++++++++++++++++
 tb/tb_fp_div.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision number model used by the FP divider and multiplier:
// field widths, bias, special encodings and the divider's controller states.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    localparam fp32_t POS_ZERO = '0;

    // Magnitude bits (exponent and mantissa) of the saturated "infinity" code.
    localparam logic [EXP_W+MAN_W-1:0] INF_MAG = {EXP_MAX, {MAN_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_DONE
    } div_state_t;

    // Denormals are flushed, so any operand with a zero exponent is zero.
    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0);
    endfunction

endpackage

// File: rtl/fp_div_mant_step.sv
// One radix-2 restoring division step: trial-subtract the divisor, keep the
// difference when it does not go negative, and shift the remainder left.
module fp_div_mant_step #(
    parameter int SW = 24
) (
    input  logic [SW:0]   rem,
    input  logic [SW-1:0] divisor,
    output logic [SW:0]   next_rem,
    output logic          q_bit
);

    logic [SW:0] diff;

    // Trial subtraction and restore-or-keep selection for a single quotient bit.
    always_comb begin
        diff     = rem - {1'b0, divisor};
        q_bit    = (rem >= {1'b0, divisor});
        next_rem = q_bit ? (diff << 1) : (rem << 1);
    end

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider. One quotient bit per cycle, truncating,
// flush-to-zero, with divide-by-zero / overflow / underflow flags held
// alongside the result until the next completion.
module fp_div #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   ready,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   dz,
    output logic                   ovf,
    output logic                   uf
);

    import fp_pkg::*;

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int SW = MAN_W + 1;
    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(RW);
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_HI = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] BIAS_LO = EW'((1 << (EXP_W - 1)) - 2);
    localparam logic signed [EW-1:0] E_TOP   = EW'((1 << EXP_W) - 2);
    localparam logic signed [EW-1:0] E_BOT   = EW'(1);

    div_state_t state;
    div_state_t state_next;

    logic                   sign;
    logic [EXP_W-1:0]       exp_a;
    logic [EXP_W-1:0]       exp_b;
    logic [RW-1:0]          rem;
    logic [RW-1:0]          rem_next;
    logic [SW-1:0]          mant_b;
    logic [RW-2:0]          q;
    logic [RW-1:0]          q_next;
    logic [CW-1:0]          cnt;
    logic                   q_bit;
    logic                   a_zero;
    logic                   b_zero;
    logic signed [EW-1:0]   exp_diff;
    logic signed [EW-1:0]   exp_norm;
    logic [MAN_W-1:0]       man_norm;

    assign a_zero = (a[W-2:MAN_W] == '0);
    assign b_zero = (b[W-2:MAN_W] == '0);

    fp_div_mant_step #(.SW(SW)) u_step (
        .rem      (rem),
        .divisor  (mant_b),
        .next_rem (rem_next),
        .q_bit    (q_bit)
    );

    // Normalise the quotient including the bit produced this cycle; only the
    // final DIVIDE cycle commits it, so the leading bit is always q[24] or q[23].
    always_comb begin
        q_next   = {q, q_bit};
        exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b});
        if (q_next[RW-1]) begin
            man_norm = q_next[RW-2:1];
            exp_norm = exp_diff + BIAS_HI;
        end else begin
            man_norm = q_next[MAN_W-1:0];
            exp_norm = exp_diff + BIAS_LO;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; special operands skip the divide loop.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = (a_zero || b_zero) ? ST_DONE : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration registers, and result/flag commit on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign   <= 1'b0;
            exp_a  <= '0;
            exp_b  <= '0;
            rem    <= '0;
            mant_b <= '0;
            q      <= '0;
            cnt    <= '0;
            result <= '0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            uf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign   <= a[W-1] ^ b[W-1];
                        exp_a  <= a[W-2:MAN_W];
                        exp_b  <= b[W-2:MAN_W];
                        rem    <= {2'b01, a[MAN_W-1:0]};
                        mant_b <= {1'b1, b[MAN_W-1:0]};
                        q      <= '0;
                        cnt    <= CW'(RW - 1);
                        if (b_zero) begin
                            result <= {a[W-1] ^ b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            dz     <= 1'b1;
                            ovf    <= 1'b0;
                            uf     <= 1'b0;
                        end else if (a_zero) begin
                            result <= '0;
                            dz     <= 1'b0;
                            ovf    <= 1'b0;
                            uf     <= 1'b0;
                        end
                    end
                end
                ST_DIVIDE: begin
                    rem <= rem_next;
                    q   <= q_next[RW-2:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        dz <= 1'b0;
                        if (exp_norm > E_TOP) begin
                            result <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            ovf    <= 1'b1;
                            uf     <= 1'b0;
                        end else if (exp_norm < E_BOT) begin
                            result <= '0;
                            ovf    <= 1'b0;
                            uf     <= 1'b1;
                        end else begin
                            result <= {sign, exp_norm[EXP_W-1:0], man_norm};
                            ovf    <= 1'b0;
                            uf     <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed corner cases, handshake behaviour,
// mid-operation reset, and randomized operands against an arithmetic model.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        dz;
    logic        ovf;
    logic        uf;

    int checks   = 0;
    int failures = 0;

    fp_div dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .dz     (dz),
        .ovf    (ovf),
        .uf     (uf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Quotient computed as floor(ma * 2^24 / mb) directly, then normalised and
    // range-checked with ordinary integer arithmetic.
    task automatic refModel(input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic edz,
                            output logic eovf, output logic euf, output int lat);
        logic            s;
        int              ea;
        int              eb;
        int              e;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned q;
        logic [22:0]     man;
        s    = av[31] ^ bv[31];
        ea   = int'(av[30:23]);
        eb   = int'(bv[30:23]);
        edz  = 1'b0;
        eovf = 1'b0;
        euf  = 1'b0;
        lat  = 26;
        if (eb == 0) begin
            r   = {s, 8'hFF, 23'h0};
            edz = 1'b1;
            lat = 1;
        end else if (ea == 0) begin
            r   = 32'h0;
            lat = 1;
        end else begin
            ma = 64'h800000 + longint'(av[22:0]);
            mb = 64'h800000 + longint'(bv[22:0]);
            q  = (ma << 24) / mb;
            if (q >= 64'd16777216) begin
                man = 23'(q >> 1);
                e   = ea - eb + 127;
            end else begin
                man = 23'(q);
                e   = ea - eb + 126;
            end
            if (e > 254) begin
                r    = {s, 8'hFF, 23'h0};
                eovf = 1'b1;
            end else if (e < 1) begin
                r   = 32'h0;
                euf = 1'b1;
            end else begin
                r = {s, 8'(e), man};
            end
        end
    endtask

    // Present a request in the current cycle; returns in cycle T+1.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat is the cycle index relative to T.
    task automatic waitDone(input int first, output int lat, output logic readyBad);
        lat      = first;
        readyBad = 1'b0;
        while (!done && lat < 40) begin
            if (ready) readyBad = 1'b1;
            tick();
            lat++;
        end
        if (ready) readyBad = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input int lat, input logic readyBad);
        logic [31:0] er;
        logic        edz;
        logic        eovf;
        logic        euf;
        int          elat;
        refModel(av, bv, er, edz, eovf, euf, elat);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".result"}, result, er);
        check({tag, ".dz"}, {31'b0, dz}, {31'b0, edz});
        check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eovf});
        check({tag, ".uf"}, {31'b0, uf}, {31'b0, euf});
        check({tag, ".ready_low"}, {31'b0, readyBad}, 32'h0);
    endtask

    // Step into the cycle after DONE: done must be gone and ready back.
    task automatic afterDone(input string tag);
        tick();
        start = 1'b0;
        check({tag, ".done_pulse"}, {31'b0, done}, 32'h0);
        check({tag, ".ready_back"}, {31'b0, ready}, 32'h1);
    endtask

    task automatic runOp(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int   lat;
        logic rb;
        applyStimulus(av, bv);
        waitDone(1, lat, rb);
        checkOutput(tag, av, bv, lat, rb);
        afterDone(tag);
    endtask

    initial begin
        int          lat;
        logic        rb;
        logic        sawDone;
        logic [31:0] av;
        logic [31:0] bv;
        int          mode;

        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset.ready", {31'b0, ready}, 32'h1);
        check("reset.done", {31'b0, done}, 32'h0);
        check("reset.result", result, 32'h0);
        check("reset.flags", {29'b0, dz, ovf, uf}, 32'h0);

        $display("[TB] directed normal-path cases");
        runOp("six_by_two", 32'h40C00000, 32'h40000000);
        check("six_by_two.exact", result, 32'h40400000);
        runOp("one_third", 32'h3F800000, 32'h40400000);
        check("one_third.exact", result, 32'h3EAAAAAA);
        runOp("neg_six", 32'hC0C00000, 32'h40000000);
        check("neg_six.exact", result, 32'hC0400000);

        $display("[TB] special operands");
        runOp("neg_by_zero", 32'hBF800000, 32'h00000000);
        check("neg_by_zero.exact", result, 32'hFF800000);
        runOp("zero_by_five", 32'h00000000, 32'h40A00000);
        runOp("zero_by_zero", 32'h00000000, 32'h00000000);
        check("zero_by_zero.dz", {31'b0, dz}, 32'h1);
        runOp("overflow", 32'h7F000000, 32'h3E800000);
        check("overflow.exact", {result[31:1], ovf}, {31'h3FC00000, 1'b1});
        runOp("underflow", 32'h00800000, 32'h40000000);
        check("underflow.exact", {result[31:1], uf}, {31'h0, 1'b1});

        $display("[TB] start ignored while busy");
        applyStimulus(32'h41200000, 32'h40800000);
        repeat (4) tick();
        a     = 32'h3F800000;
        b     = 32'h00000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(6, lat, rb);
        checkOutput("busy_ignore", 32'h41200000, 32'h40800000, lat, rb);
        a     = 32'h00000000;
        b     = 32'h00000000;
        start = 1'b1;
        afterDone("busy_ignore");
        tick();
        check("busy_ignore.not_queued", {30'b0, ready, done}, 32'h2);
        runOp("after_ignore", 32'h40490FDB, 32'h402DF854);

        $display("[TB] reset mid-division");
        applyStimulus(32'h42F60000, 32'h41100000);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset.ready", {31'b0, ready}, 32'h1);
        check("midreset.result", result, 32'h0);
        check("midreset.flags", {29'b0, dz, ovf, uf}, 32'h0);
        sawDone = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) sawDone = 1'b1;
            tick();
        end
        check("midreset.no_done", {31'b0, sawDone}, 32'h0);
        runOp("post_reset", 32'h42F60000, 32'h41100000);

        $display("[TB] randomized operands");
        for (int i = 0; i < 30; i++) begin
            av   = $urandom;
            bv   = $urandom;
            mode = int'($urandom_range(0, 7));
            if (mode == 0) bv[30:23] = 8'h00;
            if (mode == 1) av[30:23] = 8'h00;
            if (mode >= 4) begin
                av[30:23] = 8'($urandom_range(64, 190));
                bv[30:23] = 8'($urandom_range(64, 190));
            end
            runOp($sformatf("rand%0d", i), av, bv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
